// File: rtl/uart_rx_oversampled.sv
// UART receive stage: 2-flop line synchroniser, oversampled start
// detection, mid-bit data sampling and stop-bit framing check.
module uart_rx_oversampled #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int SMAX =
    (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW = $clog2(SMAX);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   s, s_nx;
  logic [NW-1:0]   n, n_nx;
  logic [DBIT-1:0] b, b_nx;
  logic [DBIT-1:0] dout_nx;
  logic            ferr_nx;
  logic            done_nx;
  logic            rx_m, rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
    end else begin
      state        <= state_nx;
      s            <= s_nx;
      n            <= n_nx;
      b            <= b_nx;
      dout         <= dout_nx;
      frame_err    <= ferr_nx;
      rx_done_tick <= done_nx;
      rx_m         <= rx;
      rx_s         <= rx_m;
    end
  end

  // Stop level is judged at the final stop tick; a high mid-start
  // sample is treated as a glitch and silently dropped.
  always_comb begin
    state_nx = state;
    s_nx     = s;
    n_nx     = n;
    b_nx     = b;
    dout_nx  = dout;
    ferr_nx  = frame_err;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          s_nx     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            s_nx = '0;
            n_nx = '0;
            state_nx = rx_s ? IDLE : DATA;
          end else begin
            s_nx = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_nx = '0;
            b_nx = {rx_s, b[DBIT-1:1]};
            if (n == N_LAST) state_nx = STOP;
            else n_nx = n + NW'(1);
          end else begin
            s_nx = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            dout_nx  = b;
            ferr_nx  = ~rx_s;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            s_nx = s + SW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 16x oversampling with
// s_tick every 4 clk, so one bit lasts 64 clk.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_rx_oversampled #(
    .DBIT(8),
    .SB_TICK(16),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .s_tick(s_tick),
    .dout(dout),
    .rx_done_tick(rx_done_tick),
    .frame_err(frame_err),
    .busy(busy)
  );

  logic       tick_en = 1'b0;
  logic [1:0] tph = 2'd0;

  always @(posedge clk) begin
    #2;
    if (tick_en) begin
      s_tick = (tph == 2'd3);
      tph = tph + 2'd1;
    end else begin
      s_tick = 1'b0;
    end
  end

  int   pulses = 0;
  int   doubles = 0;
  logic done_q = 1'b0;
  logic busy_after = 1'b1;
  logic [7:0] p_dout[$];
  logic       p_ferr[$];
  time        p_time[$];

  always @(negedge clk) begin
    if (done_q) busy_after = busy;
    if (rx_done_tick) begin
      if (done_q) doubles++;
      pulses++;
      p_dout.push_back(dout);
      p_ferr.push_back(frame_err);
      p_time.push_back($time);
    end
    done_q = rx_done_tick;
  end

  time t_start = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic align();
    int g;
    g = 0;
    while (s_tick !== 1'b1 && g < 16) begin
      @(negedge clk);
      g++;
    end
    chk("tick_align", 32'(g < 16), 32'd1);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stop_lvl,
                      input int stop_len,
                      input int stall_bit,
                      input int stall_len);
    align();
    t_start = $time;
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == stall_bit) begin
        wait_clk(16);
        tick_en = 1'b0;
        wait_clk(stall_len);
        tick_en = 1'b1;
        wait_clk(48);
      end else begin
        wait_clk(64);
      end
    end
    rx = stop_lvl;
    wait_clk(stop_len);
    rx = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick_en = 1'b1;
    wait_clk(5);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_done", 32'(rx_done_tick), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_clk(10);

    send(8'hA5, 1'b1, 64, -1, 0);
    chk("a5_pulses", 32'(pulses), 32'd1);
    chk("a5_dout", 32'(p_dout[0]), 32'hA5);
    chk("a5_ferr", 32'(p_ferr[0]), 32'd0);
    chk("a5_latency", 32'(int'(p_time[0] - t_start)),
        32'd6090);
    chk("a5_busy_after", 32'(busy_after), 32'd0);
    chk("a5_hold", 32'(dout), 32'hA5);

    send(8'h00, 1'b1, 64, -1, 0);
    send(8'hFF, 1'b1, 64, -1, 0);
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_dout0", 32'(p_dout[1]), 32'h00);
    chk("b2b_dout1", 32'(p_dout[2]), 32'hFF);
    chk("b2b_ferr0", 32'(p_ferr[1]), 32'd0);
    chk("b2b_ferr1", 32'(p_ferr[2]), 32'd0);
    chk("b2b_gap", 32'(int'(p_time[2] - p_time[1])),
        32'd6400);

    send(8'h3C, 1'b0, 48, -1, 0);
    wait_clk(200);
    chk("fe_pulses", 32'(pulses), 32'd4);
    chk("fe_dout", 32'(p_dout[3]), 32'h3C);
    chk("fe_ferr", 32'(p_ferr[3]), 32'd1);
    chk("fe_hold", 32'(frame_err), 32'd1);
    chk("fe_idle", 32'(busy), 32'd0);
    send(8'h11, 1'b1, 64, -1, 0);
    wait_clk(20);
    chk("ok_pulses", 32'(pulses), 32'd5);
    chk("ok_dout", 32'(dout), 32'h11);
    chk("ok_ferr", 32'(frame_err), 32'd0);

    align();
    rx = 1'b0;
    wait_clk(10);
    chk("gl_busy", 32'(busy), 32'd1);
    wait_clk(10);
    rx = 1'b1;
    wait_clk(80);
    chk("gl_idle", 32'(busy), 32'd0);
    chk("gl_pulses", 32'(pulses), 32'd5);
    chk("gl_dout", 32'(dout), 32'h11);
    chk("gl_ferr", 32'(frame_err), 32'd0);

    align();
    rx = 1'b0;
    wait_clk(64);
    rx = 1'b0;
    wait_clk(64);
    rx = 1'b1;
    wait_clk(64);
    rx = 1'b0;
    wait_clk(64);
    rx = 1'b1;
    wait_clk(32);
    reset = 1'b1;
    wait_clk(1);
    chk("mr_dout", 32'(dout), 32'h00);
    chk("mr_done", 32'(rx_done_tick), 32'd0);
    chk("mr_ferr", 32'(frame_err), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(700);
    chk("mr_nopulse", 32'(pulses), 32'd5);
    send(8'h81, 1'b1, 64, -1, 0);
    chk("mr_pulses", 32'(pulses), 32'd6);
    chk("mr_p_dout", 32'(p_dout[5]), 32'h81);
    chk("mr_dout81", 32'(dout), 32'h81);
    chk("mr_ferr81", 32'(frame_err), 32'd0);

    send(8'h96, 1'b1, 64, 3, 200);
    chk("st_pulses", 32'(pulses), 32'd7);
    chk("st_dout", 32'(p_dout[6]), 32'h96);
    chk("st_ferr", 32'(p_ferr[6]), 32'd0);
    chk("st_latency", 32'(int'(p_time[6] - t_start)),
        32'd8090);

    wait_clk(20);
    chk("no_double", 32'(doubles), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
